// File: rtl/pe_responder_if.sv
// Leaf-port bundle between the BFT network and a responder PE.
// master: network side (drives interface_pe and resend).
// slave:  PE side (drives pe_interface).
interface pe_responder_if #(
  parameter int p_sz = 49
);
  logic [p_sz-1:0] interface_pe;
  logic [p_sz-1:0] pe_interface;
  logic            resend;

  modport master (
    output interface_pe,
    output resend,
    input  pe_interface
  );

  modport slave (
    input  interface_pe,
    input  resend,
    output pe_interface
  );
endinterface

// File: rtl/pe_responder.sv
// Leaf-side responder PE for the BFT network.
// Queues packets addressed to this leaf in a small FIFO and answers each one
// with a reply sent back to its source, data incremented by one. A reply is
// held on pe_interface until the network stops asserting resend.
// Optional statistics counters are built when PE_RESPONDER_STATS_EN is
// defined; otherwise rx_count, tx_count and drop_count are tied to 0.
module pe_responder #(
  parameter int num_leaves = 32,
  parameter int payload_sz = 43,
  parameter int p_sz       = 49,
  parameter int addr       = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  pe_responder_if.slave                 net,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   rx_count,
  output logic [15:0]                   tx_count,
  output logic [15:0]                   drop_count
);

  localparam int A  = $clog2(num_leaves);
  localparam int D  = payload_sz - A;
  localparam int E  = A + D;
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [A-1:0]  MY_ADDR = A'(addr);
  localparam logic [PW:0]   FULL_LEVEL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t state;

  // Incoming packet fields.
  logic         rx_valid;
  logic [A-1:0] rx_dest;
  logic [A-1:0] rx_src;
  logic [D-1:0] rx_data;

  assign rx_valid = net.interface_pe[p_sz-1];
  assign rx_dest  = net.interface_pe[p_sz-2 -: A];
  assign rx_src   = net.interface_pe[p_sz-2-A -: A];
  assign rx_data  = net.interface_pe[D-1:0];

  // FIFO storage: each entry keeps only what the reply needs (src, data).
  logic [E-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic empty;
  logic full;
  logic pop;
  logic push;

  assign empty = (count == '0);
  assign full  = (count == FULL_LEVEL);

  // A pop happens whenever the output register is free to take a new reply:
  // always in IDLE, and in SEND only when the current word is accepted.
  assign pop  = !empty && ((state == IDLE) || !net.resend);

  // Full is judged on pre-edge occupancy; a simultaneous pop frees a slot.
  assign push = rx_valid && (rx_dest == MY_ADDR) && (!full || pop);

  // Reply assembled from the FIFO head.
  logic [E-1:0]    head;
  logic [A-1:0]    head_src;
  logic [D-1:0]    head_data;
  logic [p_sz-1:0] reply;

  assign head      = mem[rd_ptr];
  assign head_src  = head[E-1 -: A];
  assign head_data = head[D-1:0];
  assign reply     = {1'b1, head_src, MY_ADDR, head_data + D'(1)};

  assign fifo_level = count;

  // FIFO data write.
  // NOTE: the storage array has no reset; pointers and count decide which
  // entries are meaningful, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {rx_src, rx_data};
    end
  end

  // FIFO pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
    end
  end

  // Reply FSM with registered output word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      net.pe_interface <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            net.pe_interface <= reply;
            state            <= SEND;
          end
        end
        SEND: begin
          if (!net.resend) begin
            if (!empty) begin
              net.pe_interface <= reply;
            end else begin
              net.pe_interface <= '0;
              state            <= IDLE;
            end
          end
        end
        default: begin
          net.pe_interface <= '0;
          state            <= IDLE;
        end
      endcase
    end
  end

`ifdef PE_RESPONDER_STATS_EN
  logic drop;
  logic tx_accept;

  assign drop      = rx_valid && !push;
  assign tx_accept = (state == SEND) && !net.resend;

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_count   <= '0;
      tx_count   <= '0;
      drop_count <= '0;
    end else begin
      if (push && rx_count != 16'hFFFF)        rx_count   <= rx_count + 16'd1;
      if (tx_accept && tx_count != 16'hFFFF)   tx_count   <= tx_count + 16'd1;
      if (drop && drop_count != 16'hFFFF)      drop_count <= drop_count + 16'd1;
    end
  end
`else
  assign rx_count   = '0;
  assign tx_count   = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_pe_responder.sv
// Directed testbench for pe_responder (addr=3, 32 leaves, 49-bit packets,
// 4-entry FIFO). Counter expectations follow PE_RESPONDER_STATS_EN: the
// hand-computed value when it is defined, 0 when it is not.
module tb_pe_responder;

  localparam int P = 49;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  fifo_level;
  logic [15:0] rx_count;
  logic [15:0] tx_count;
  logic [15:0] drop_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pe_responder_if #(.p_sz(P)) net ();

  pe_responder #(
    .num_leaves (32),
    .payload_sz (43),
    .p_sz       (P),
    .addr       (3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .net        (net),
    .fifo_level (fifo_level),
    .rx_count   (rx_count),
    .tx_count   (tx_count),
    .drop_count (drop_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] st(input logic [15:0] v);
`ifdef PE_RESPONDER_STATS_EN
    return v;
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic [P-1:0] mk_pkt(input logic [4:0] d, input logic [4:0] s,
                                          input logic [37:0] data);
    return {1'b1, d, s, data};
  endfunction

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    net.interface_pe = '0;
    net.resend       = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_counters(input string tag, input logic [15:0] rx,
                                input logic [15:0] tx, input logic [15:0] dr);
    check({tag, "_rx"},   64'(rx_count),   64'(st(rx)));
    check({tag, "_tx"},   64'(tx_count),   64'(st(tx)));
    check({tag, "_drop"}, 64'(drop_count), 64'(st(dr)));
  endtask

  logic [4:0] order [6];

  initial begin
    reset            = 1'b1;
    net.interface_pe = '0;
    net.resend       = 1'b0;

    // Reset state.
    do_reset();
    check("rst_pe", 64'(net.pe_interface), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check_counters("rst", 16'd0, 16'd0, 16'd0);

    // 1. Single packet: one-cycle reply then idle.
    net.interface_pe = mk_pkt(5'd3, 5'd7, 38'h10);
    tick();
    net.interface_pe = '0;
    check("s1_pe_t0", 64'(net.pe_interface), 64'd0);
    check("s1_level_t0", 64'(fifo_level), 64'd1);
    tick();
    check("s1_reply", 64'(net.pe_interface), 64'(mk_pkt(5'd7, 5'd3, 38'h11)));
    check("s1_level_t1", 64'(fifo_level), 64'd0);
    tick();
    check("s1_pe_idle", 64'(net.pe_interface), 64'd0);
    check_counters("s1", 16'd1, 16'd1, 16'd0);

    // 2. Retry: resend for the first 3 reply cycles holds the word 4 cycles.
    do_reset();
    net.interface_pe = mk_pkt(5'd3, 5'd7, 38'h10);
    tick();
    net.interface_pe = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s2_hold%0d", i), 64'(net.pe_interface),
            64'(mk_pkt(5'd7, 5'd3, 38'h11)));
      net.resend = (i < 3);
      tick();
    end
    check("s2_pe_idle", 64'(net.pe_interface), 64'd0);
    check_counters("s2", 16'd1, 16'd1, 16'd0);

    // 3. Overflow under resend, then drain; a push on a full FIFO that
    //    coincides with a pop is accepted (src 7 follows src 5).
    do_reset();
    net.resend = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      net.interface_pe = mk_pkt(5'd3, 5'(i), 38'(32'h100 + i));
      tick();
    end
    net.interface_pe = '0;
    check("s3_held", 64'(net.pe_interface), 64'(mk_pkt(5'd1, 5'd3, 38'h102)));
    check("s3_level_full", 64'(fifo_level), 64'd4);
    check_counters("s3_full", 16'd5, 16'd0, 16'd1);
    order[0] = 5'd1; order[1] = 5'd2; order[2] = 5'd3;
    order[3] = 5'd4; order[4] = 5'd5; order[5] = 5'd7;
    net.resend = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("s3_reply%0d", k), 64'(net.pe_interface),
            64'(mk_pkt(order[k], 5'd3, 38'(32'h101 + order[k]))));
      net.interface_pe = (k == 0) ? mk_pkt(5'd3, 5'd7, 38'h107) : '0;
      tick();
      if (k == 0) check("s3_level_pushpop", 64'(fifo_level), 64'd4);
    end
    check("s3_pe_idle", 64'(net.pe_interface), 64'd0);
    check("s3_level_end", 64'(fifo_level), 64'd0);
    check_counters("s3_end", 16'd6, 16'd6, 16'd1);

    // 4. Misroute: dest 9 is dropped.
    do_reset();
    net.interface_pe = mk_pkt(5'd9, 5'd1, 38'h55);
    tick();
    net.interface_pe = '0;
    check("s4_level", 64'(fifo_level), 64'd0);
    tick();
    check("s4_pe", 64'(net.pe_interface), 64'd0);
    check_counters("s4", 16'd0, 16'd0, 16'd1);

    // 5. Data wrap: all-ones data replies with 0.
    do_reset();
    net.interface_pe = mk_pkt(5'd3, 5'd2, 38'h3F_FFFF_FFFF);
    tick();
    net.interface_pe = '0;
    tick();
    check("s5_wrap", 64'(net.pe_interface), 64'(mk_pkt(5'd2, 5'd3, 38'h0)));

    // 6. Asynchronous reset during a retry with one packet still queued.
    do_reset();
    net.interface_pe = mk_pkt(5'd3, 5'd7, 38'h10);
    tick();
    net.interface_pe = mk_pkt(5'd3, 5'd8, 38'h20);
    tick();
    net.interface_pe = '0;
    net.resend       = 1'b1;
    tick();
    check("s6_pre_pe", 64'(net.pe_interface), 64'(mk_pkt(5'd7, 5'd3, 38'h11)));
    check("s6_pre_level", 64'(fifo_level), 64'd1);
    check("s6_pre_rx", 64'(rx_count), 64'(st(16'd2)));
    #2;
    reset = 1'b1;
    #1;
    check("s6_async_pe", 64'(net.pe_interface), 64'd0);
    check("s6_async_level", 64'(fifo_level), 64'd0);
    check_counters("s6_async", 16'd0, 16'd0, 16'd0);
    tick();
    reset      = 1'b0;
    net.resend = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("s6_after%0d", i), 64'(net.pe_interface), 64'd0);
    end
    check("s6_after_level", 64'(fifo_level), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
